decode_stage: RTL and testbench

- Registered, elastic instruction-decode stage between fetch and execute in the sequential RISC-V core.
- Decodes one 32-bit instruction per cycle into class codes (ib/sb), ALU select (op_s), XLEN-wide immediate and register indices.
- Adds JALR, SYSTEM and illegal-instruction detection, a valid/ready handshake with a 2-entry skid buffer, flush, and a saturating illegal-instruction counter.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, elastic RV32/RV64 instruction-decode stage.
// Decodes one instruction per cycle into class codes, ALU select, a sign-extended
// immediate and register indices, then queues the result in a 2-entry skid buffer
// with a valid/ready handshake, flush, and a saturating illegal-instruction counter.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_ib,
    output logic [4:0]       out_sb,
    output logic [3:0]       out_op_s,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      ib;
        logic [4:0]      sb;
        logic [3:0]      op_s;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    entry_t          slot_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;
    logic [1:0]      count_next;
    logic            in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic            accept;
    logic            deq;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
    logic            legal;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Immediates are assembled at their natural width and sign-extended to XLEN.
    assign i_imm = XLEN'($signed(in_instr[31:20]));
    assign s_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign b_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign u_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign j_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    // Combinational decode of the incoming instruction word.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.op_s    = {1'b0, funct3};
        legal       = 1'b1;
        unique case (opcode)
            OP_R: begin
                dec.ib   = 5'd5;
                dec.op_s = {in_instr[30], funct3};
                legal    = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            OP_IARITH: begin
                dec.ib  = 5'd7;
                dec.imm = i_imm;
                // Only shifts use bit 30 (arithmetic vs logical right shift).
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.op_s = {in_instr[30], funct3};
                end
            end
            OP_LOAD:   begin dec.ib = 5'd1;  dec.sb = 5'd9; dec.imm = i_imm; end
            OP_STORE:  begin dec.ib = 5'd1;  dec.sb = 5'd3; dec.imm = s_imm; end
            OP_LUI:    begin dec.ib = 5'd2;  dec.imm = u_imm; end
            OP_AUIPC:  begin dec.ib = 5'd4;  dec.imm = u_imm; end
            OP_BRANCH: begin dec.ib = 5'd12; dec.imm = b_imm; end
            OP_JAL:    begin dec.ib = 5'd16; dec.imm = j_imm; end
            OP_JALR:   begin dec.ib = 5'd20; dec.imm = i_imm; end
            OP_SYSTEM: begin dec.ib = 5'd24; dec.imm = i_imm; end
            default:   legal = 1'b0;
        endcase
        // Illegal entries keep pc and register fields but zero the decoded fields.
        if (!legal || in_instr[1:0] != 2'b11 || in_instr == 32'h0) begin
            dec.illegal = 1'b1;
            dec.ib      = '0;
            dec.sb      = '0;
            dec.op_s    = '0;
            dec.imm     = '0;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready_q & ~flush;
    assign deq       = out_valid & out_ready;

    // Occupancy after this cycle's enqueue/dequeue; simultaneous both leaves it unchanged.
    always_comb begin
        count_next = count_q;
        if (accept && !deq) begin
            count_next = count_q + 2'd1;
        end else if (!accept && deq) begin
            count_next = count_q - 2'd1;
        end
    end

    // Skid-buffer storage, pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two slots are reset so the output data fields read zero after reset.
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                slot_q[wr_ptr_q] <= dec;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_next;
            in_ready_q <= (count_next != 2'd2);
        end
    end

    // Saturating count of accepted illegal instructions; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign in_ready    = in_ready_q;
    assign illegal_cnt = cnt_q;
    assign out_pc      = slot_q[rd_ptr_q].pc;
    assign out_ib      = slot_q[rd_ptr_q].ib;
    assign out_sb      = slot_q[rd_ptr_q].sb;
    assign out_op_s    = slot_q[rd_ptr_q].op_s;
    assign out_imm     = slot_q[rd_ptr_q].imm;
    assign out_rs1     = slot_q[rd_ptr_q].rs1;
    assign out_rs2     = slot_q[rd_ptr_q].rs2;
    assign out_rd      = slot_q[rd_ptr_q].rd;
    assign out_illegal = slot_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// A 32-bit instance (CNT_W=8) and a 64-bit instance (CNT_W=2) share the same stimulus,
// so sign extension to 64 bits and counter saturation are exercised in one run.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_ib, out_sb, out_rs1, out_rs2, out_rd;
    logic [3:0]  out_op_s;
    logic [7:0]  illegal_cnt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_pc64, out_imm64;
    logic [4:0]  out_ib64, out_sb64, out_rs164, out_rs264, out_rd64;
    logic [3:0]  out_op_s64;
    logic [1:0]  illegal_cnt64;

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(pc[31:0]),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ib(out_ib), .out_sb(out_sb), .out_op_s(out_op_s), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(pc),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .out_ib(out_ib64), .out_sb(out_sb64), .out_op_s(out_op_s64), .out_imm(out_imm64),
        .out_rs1(out_rs164), .out_rs2(out_rs264), .out_rd(out_rd64),
        .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] p);
        in_valid = v;
        in_instr = instr;
        pc       = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cnt", illegal_cnt, 0);
        check("rst_ib", out_ib, 0);
        check("rst_imm", out_imm, 0);
        check("rst_pc", out_pc, 0);
        rst = 1'b0;

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 64'h100);
        step();
        check("addi_valid", out_valid, 1);
        check("addi_ib", out_ib, 7);
        check("addi_sb", out_sb, 0);
        check("addi_op_s", out_op_s, 4'b0000);
        check("addi_imm", out_imm, 5);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_pc", out_pc, 32'h100);

        // sub x2,x1,x2
        drive(1'b1, 32'h40208133, 64'h104);
        step();
        check("sub_ib", out_ib, 5);
        check("sub_op_s", out_op_s, 4'b1000);
        check("sub_imm", out_imm, 0);
        check("sub_rs2", out_rs2, 2);
        check("sub_pc", out_pc, 32'h104);

        // lw x1,-1(x1)
        drive(1'b1, 32'hFFF0A083, 64'h108);
        step();
        check("lw_ib", out_ib, 1);
        check("lw_sb", out_sb, 9);
        check("lw_op_s", out_op_s, 4'b0010);
        check("lw_imm", out_imm, 32'hFFFF_FFFF);
        check("lw_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        // srai x1,x1,1
        drive(1'b1, 32'h4010D093, 64'h10C);
        step();
        check("srai_op_s", out_op_s, 4'b1101);
        check("srai_imm", out_imm, 32'h401);

        // addi with bit 30 set: bit 30 is immediate, not an ALU modifier
        drive(1'b1, 32'h40008093, 64'h110);
        step();
        check("addi30_op_s", out_op_s, 4'b0000);
        check("addi30_imm", out_imm, 32'h400);

        // sw x1,-4(x2)
        drive(1'b1, 32'hFE112E23, 64'h114);
        step();
        check("sw_ib", out_ib, 1);
        check("sw_sb", out_sb, 3);
        check("sw_imm", out_imm, 32'hFFFF_FFFC);

        // lui x1,0x80000
        drive(1'b1, 32'h800000B7, 64'h118);
        step();
        check("lui_ib", out_ib, 2);
        check("lui_imm", out_imm, 32'h8000_0000);
        check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);

        // jal x0,-4
        drive(1'b1, 32'hFFDFF06F, 64'h11C);
        step();
        check("jal_ib", out_ib, 16);
        check("jal_op_s", out_op_s, 4'b0111);
        check("jal_imm", out_imm, 32'hFFFF_FFFC);
        check("jal_pc64", out_pc64, 64'h11C);

        drive(1'b0, 32'h0, 64'h0);
        step();
        check("drain_valid", out_valid, 0);

        // Backpressure: A and B fill the buffer, C is held off.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h200);
        step();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_ready", in_ready, 1);
        drive(1'b1, 32'h00200113, 64'h204);
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_hold_pc", out_pc, 32'h200);
        drive(1'b1, 32'h00300193, 64'h208);
        step();
        check("bp_stall_ready", in_ready, 0);
        check("bp_stall_pc", out_pc, 32'h200);
        check("bp_stall_imm", out_imm, 1);
        out_ready = 1'b1;
        step();
        check("bp_b_pc", out_pc, 32'h204);
        check("bp_b_imm", out_imm, 2);
        check("bp_b_ready", in_ready, 1);
        step();
        check("bp_c_pc", out_pc, 32'h208);
        check("bp_c_imm", out_imm, 3);
        drive(1'b0, 32'h0, 64'h0);
        step();
        check("bp_empty", out_valid, 0);

        // Illegal instructions
        drive(1'b1, 32'h00000000, 64'h300);
        step();
        check("ill0_flag", out_illegal, 1);
        check("ill0_ib", out_ib, 0);
        check("ill0_pc", out_pc, 32'h300);
        check("ill0_cnt", illegal_cnt, 1);
        drive(1'b1, 32'hFFFFFFFF, 64'h304);
        step();
        check("illF_flag", out_illegal, 1);
        check("illF_ib", out_ib, 0);
        check("illF_rd", out_rd, 31);
        drive(1'b1, 32'h02000033, 64'h308);
        step();
        check("ill7_flag", out_illegal, 1);
        check("ill7_op_s", out_op_s, 0);
        check("ill7_cnt", illegal_cnt, 3);
        check("ill7_cnt64", illegal_cnt64, 3);
        drive(1'b1, 32'h0000007F, 64'h30C);
        step();
        drive(1'b1, 32'hFFFFFFFF, 64'h310);
        step();
        check("ill_cnt5", illegal_cnt, 5);
        check("ill_sat", illegal_cnt64, 3);

        // Flush with a full buffer and an illegal word on the input
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h400);
        step();
        drive(1'b1, 32'h00200113, 64'h404);
        step();
        check("fl_full", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'h00000000, 64'h408);
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_cnt", illegal_cnt, 5);

        // Reset mid-stream
        drive(1'b1, 32'h00500093, 64'h500);
        step();
        check("mr_valid", out_valid, 1);
        rst = 1'b1;
        step();
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_cnt", illegal_cnt, 0);
        check("mr_pc", out_pc, 0);
        check("mr_imm", out_imm, 0);
        check("mr_ib", out_ib, 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
